// File: rtl/upsample_input_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : upsample_input_loader                                           |
// | Purpose  : Packs a raster-order element stream into the flat frame vector  |
// |            for top_upsample, then launches it and waits for done.          |
// | Options  : UPSAMPLE_LOADER_PINGPONG_EN adds a second bank to fill in WAIT. |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module upsample_input_loader #(
  parameter int NUMBER_OF_ROW = 4,
  parameter int LENGTH        = 12,
  parameter int CNT_W         = 16
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          s_valid,
  input  logic [LENGTH-1:0]                             s_data,
  input  logic                                          s_last,
  output logic                                          s_ready,
  output logic [LENGTH*NUMBER_OF_ROW*NUMBER_OF_ROW-1:0] up_din,
  output logic                                          up_start,
  input  logic                                          up_done,
  output logic                                          busy,
  output logic [CNT_W-1:0]                              frame_cnt,
  output logic                                          frame_err
);

  localparam int ELEMS = NUMBER_OF_ROW * NUMBER_OF_ROW;
  localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(ELEMS - 1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic              r_done_q;
  logic              r_up_start;
  logic              r_busy;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic              r_frame_err;

  logic w_accept;
  logic w_last_beat;
  logic w_done_rise;

  // Edge detect so a done level left high from the previous frame is ignored.
  assign w_done_rise = up_done & ~r_done_q;
  assign w_last_beat = (r_idx == c_LAST_IDX);
  assign w_accept    = s_valid & s_ready;

  assign up_start  = r_up_start;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
  assign frame_err = r_frame_err;

`ifdef UPSAMPLE_LOADER_PINGPONG_EN

  logic [LENGTH-1:0] r_bank_a [ELEMS];
  logic [LENGTH-1:0] r_bank_b [ELEMS];
  logic              r_fill_sel;
  logic              r_launch_sel;
  logic              r_pending;

  // A pending bank exists only in WAIT, so this also covers FILL and LAUNCH.
  assign s_ready = ~r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_FILL;
      r_idx        <= '0;
      r_done_q     <= 1'b0;
      r_up_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
      r_frame_err  <= 1'b0;
      r_fill_sel   <= 1'b0;
      r_launch_sel <= 1'b0;
      r_pending    <= 1'b0;
      for (int i = 0; i < ELEMS; i++) begin
        r_bank_a[i] <= '0;
        r_bank_b[i] <= '0;
      end
    end else begin
      r_done_q   <= up_done;
      r_up_start <= 1'b0;
      if (w_accept) begin
        if (r_fill_sel) r_bank_b[r_idx] <= s_data;
        else            r_bank_a[r_idx] <= s_data;
        r_idx <= w_last_beat ? '0 : r_idx + IDX_W'(1);
        if (s_last != w_last_beat) r_frame_err <= 1'b1;
        if (w_last_beat && r_state != ST_FILL) r_pending <= 1'b1;
      end
      case (r_state)
        ST_FILL: begin
          if (w_accept && w_last_beat) begin
            r_state      <= ST_LAUNCH;
            r_up_start   <= 1'b1;
            r_busy       <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
            r_launch_sel <= r_fill_sel;
            r_fill_sel   <= ~r_fill_sel;
          end
        end
        ST_LAUNCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_done_rise) begin
            if (r_pending || (w_accept && w_last_beat)) begin
              // Back-to-back launch: the finished bank becomes the fill bank.
              r_state      <= ST_LAUNCH;
              r_up_start   <= 1'b1;
              r_frame_cnt  <= r_frame_cnt + CNT_W'(1);
              r_launch_sel <= r_fill_sel;
              r_fill_sel   <= ~r_fill_sel;
              r_pending    <= 1'b0;
            end else begin
              r_state <= ST_FILL;
              r_busy  <= 1'b0;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  for (genvar g = 0; g < ELEMS; g++) begin : g_din
    assign up_din[g*LENGTH +: LENGTH] = r_launch_sel ? r_bank_b[g] : r_bank_a[g];
  end

`else

  logic [LENGTH-1:0] r_bank [ELEMS];

  assign s_ready = (r_state == ST_FILL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_done_q    <= 1'b0;
      r_up_start  <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_frame_err <= 1'b0;
      for (int i = 0; i < ELEMS; i++) r_bank[i] <= '0;
    end else begin
      r_done_q   <= up_done;
      r_up_start <= 1'b0;
      if (w_accept) begin
        r_bank[r_idx] <= s_data;
        r_idx         <= w_last_beat ? '0 : r_idx + IDX_W'(1);
        if (s_last != w_last_beat) r_frame_err <= 1'b1;
      end
      case (r_state)
        ST_FILL: begin
          if (w_accept && w_last_beat) begin
            r_state     <= ST_LAUNCH;
            r_up_start  <= 1'b1;
            r_busy      <= 1'b1;
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          end
        end
        ST_LAUNCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_done_rise) begin
            r_state <= ST_FILL;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // The bank is only written in FILL, so up_din is frozen from LAUNCH to done.
  for (genvar g = 0; g < ELEMS; g++) begin : g_din
    assign up_din[g*LENGTH +: LENGTH] = r_bank[g];
  end

`endif

endmodule

`default_nettype wire

// File: tb/tb_upsample_input_loader.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_upsample_input_loader                                        |
// | Purpose  : Directed self-checking bench for upsample_input_loader.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_upsample_input_loader;

  localparam int NR    = 4;
  localparam int LEN   = 12;
  localparam int CW    = 16;
  localparam int ELEMS = NR * NR;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  s_valid;
  logic [LEN-1:0]        s_data;
  logic                  s_last;
  logic                  s_ready;
  logic [LEN*ELEMS-1:0]  up_din;
  logic                  up_start;
  logic                  up_done;
  logic                  busy;
  logic [CW-1:0]         frame_cnt;
  logic                  frame_err;

  int checks   = 0;
  int failures = 0;

  upsample_input_loader #(.NUMBER_OF_ROW(NR), .LENGTH(LEN), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .up_din    (up_din),
    .up_start  (up_start),
    .up_done   (up_done),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] elem(input int k);
    return 32'(up_din[k*LEN +: LEN]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n beats of base+mul*i; s_last only on beat last_pos.
  task automatic send(input int base, input int mul, input int n, input int last_pos);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = LEN'(base + mul * i);
      s_last  = (i == last_pos);
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic pulse_done();
    up_done = 1'b1;
    step();
    up_done = 1'b0;
  endtask

  logic [LEN*ELEMS-1:0] snap;
  int n_start, n_ready, n_chg;

  initial begin
    rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; up_done = 1'b0;
    step(); step();
    chk("rst_up_start", up_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_din_zero", 32'(up_din != '0), 0);
    rst = 1'b1;
    step();
    chk("rel_ready", s_ready, 1);

    // Frame 1: 35+10*i
    send(35, 10, 16, 15);
    chk("f1_start", up_start, 1);
    chk("f1_busy", busy, 1);
    chk("f1_ready_low", s_ready, 0);
    chk("f1_e0", elem(0), 35);
    chk("f1_e5", elem(5), 85);
    chk("f1_e15", elem(15), 185);
    step();
    chk("f1_start_once", up_start, 0);
    chk("f1_cnt", frame_cnt, 1);
    chk("f1_err", frame_err, 0);

    // Hold in WAIT with upstream pushing
    snap = up_din; n_start = 0; n_ready = 0; n_chg = 0;
    s_valid = 1'b1; s_data = LEN'(999);
    for (int i = 0; i < 50; i++) begin
      step();
      if (up_start) n_start++;
      if (s_ready) n_ready++;
      if (up_din !== snap) n_chg++;
    end
    s_valid = 1'b0;
    chk("wait_no_start", n_start, 0);
    chk("wait_no_ready", n_ready, 0);
    chk("wait_din_frozen", n_chg, 0);
    chk("wait_busy", busy, 1);
    pulse_done();
    chk("done_ready", s_ready, 1);
    chk("done_busy", busy, 0);
    step();
    chk("done_ready2", s_ready, 1);

    // Frame 2, then level-style done left high
    send(100, 1, 16, 15);
    chk("f2_start", up_start, 1);
    chk("f2_e3", elem(3), 103);
    step(); step();
    up_done = 1'b1;
    step();
    chk("f2_done_busy", busy, 0);
    // Frame 3 with done still high from frame 2
    send(300, 2, 16, 15);
    chk("f3_start", up_start, 1);
    for (int i = 0; i < 10; i++) step();
    chk("f3_stuck_busy", busy, 1);
    chk("f3_stuck_ready", s_ready, 0);
    up_done = 1'b0;
    step();
    chk("f3_drop_busy", busy, 1);
    up_done = 1'b1;
    step();
    chk("f3_rise_busy", busy, 0);
    chk("f3_cnt", frame_cnt, 3);
    chk("f3_e15", elem(15), 330);
    up_done = 1'b0;
    step();

    // Frame 4: s_last on beat 7, missing on beat 15
    send(200, 1, 16, 7);
    chk("f4_start", up_start, 1);
    chk("f4_err", frame_err, 1);
    chk("f4_e15", elem(15), 215);
    step();
    chk("f4_cnt", frame_cnt, 4);
    pulse_done();
    step();
    send(400, 1, 16, 15);
    chk("f5_start", up_start, 1);
    chk("f5_err_sticky", frame_err, 1);
    step();
    chk("f5_cnt", frame_cnt, 5);
    pulse_done();
    step();

    // Async reset mid-frame at beat 9
    send(10, 1, 9, 99);
    #2 rst = 1'b0;
    #1;
    chk("arst_cnt", frame_cnt, 0);
    chk("arst_err", frame_err, 0);
    chk("arst_din_zero", 32'(up_din != '0), 0);
    step();
    rst = 1'b1;
    step();
    send(60, 1, 16, 15);
    chk("f6_start", up_start, 1);
    step(); step();
    #2 rst = 1'b0;
    #1;
    chk("arst_wait_busy", busy, 0);
    chk("arst_wait_cnt", frame_cnt, 0);
    chk("arst_wait_din", 32'(up_din != '0), 0);
    step();
    rst = 1'b1;
    step();
    chk("rel2_ready", s_ready, 1);
    send(50, 1, 16, 15);
    chk("f7_start", up_start, 1);
    chk("f7_e0", elem(0), 50);
    chk("f7_e15", elem(15), 65);
    step();
    chk("f7_cnt", frame_cnt, 1);
    chk("f7_err", frame_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
